msoc_mem_copy_dma: RTL and testbench

Avalon-MM block-copy engine that sits directly upstream of the 8192x32 single-port on-chip RAM and drives its slave port (address, byteenable, chipselect, write, writedata, clken; reads return on readdata).
The CPU programs source word address, destination word address and word count through a 4-register CSR slave.
The engine then moves the data word-by-word: read, capture, write.
It raises done, with an optional interrupt, when the copy completes.

---
 rtl/msoc_mem_copy_dma.sv | 148 ++++++++++++++
 tb/tb_msoc_mem_copy_dma.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msoc_mem_copy_dma.sv
// Avalon-MM block-copy engine for the 8192x32 on-chip RAM.
// CPU programs SRC/DST/LEN via a 4-register CSR slave; each word costs read, capture, write.
module msoc_mem_copy_dma #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 14
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        s_address,
   input  logic              s_chipselect,
   input  logic              s_write,
   input  logic              s_read,
   input  logic [31:0]       s_writedata,
   output logic [31:0]       s_readdata,
   output logic              irq,
   output logic [ADDR_W-1:0] m_address,
   output logic [3:0]        m_byteenable,
   output logic              m_chipselect,
   output logic              m_write,
   output logic [DATA_W-1:0] m_writedata,
   output logic              m_clken,
   input  logic [DATA_W-1:0] m_readdata
);

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_CAP, ST_WR} state_t;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

   state_t              r_state, w_next;
   logic [ADDR_W-1:0]   r_src, r_dst, r_src_ptr, r_dst_ptr;
   logic [LEN_W-1:0]    r_len, r_rem;
   logic [DATA_W-1:0]   r_buf;
   logic                r_done, r_aborted, r_irq_en, r_abort_pend;

   logic                w_busy, w_csr_wr, w_ctrl_wr, w_start, w_abort, w_finish;
   logic [LEN_W-1:0]    w_len_in, w_len_sat, w_rem_dec;
   logic                w_unused;

   assign w_busy    = (r_state != ST_IDLE);
   assign w_csr_wr  = s_chipselect & s_write;
   assign w_ctrl_wr = w_csr_wr & (s_address == 2'd3);
   assign w_start   = w_ctrl_wr & s_writedata[0] & ~w_busy;
   assign w_len_in  = s_writedata[LEN_W-1:0];
   assign w_len_sat = (w_len_in > MAX_LEN) ? MAX_LEN : w_len_in;
   assign w_rem_dec = r_rem - LEN_W'(1);
   // An abort written during the closing WR cycle takes effect on that same word boundary.
   assign w_abort   = r_abort_pend | (w_ctrl_wr & s_writedata[3]);
   assign w_finish  = (r_state == ST_WR) & ((w_rem_dec == '0) | w_abort);
   assign w_unused  = &{1'b0, s_read, s_writedata[31:LEN_W]};

   assign irq          = r_done & r_irq_en;
   assign m_byteenable = 4'hF;
   assign m_clken      = reset_n;
   assign m_writedata  = r_buf;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      m_chipselect = 1'b0;
      m_write      = 1'b0;
      m_address    = '0;
      case (r_state)
         ST_IDLE: if (w_start && (r_len != '0)) w_next = ST_RD;
         ST_RD: begin
            m_chipselect = 1'b1;
            m_address    = r_src_ptr;
            w_next       = ST_CAP;
         end
         ST_CAP: w_next = ST_WR;
         ST_WR: begin
            m_chipselect = 1'b1;
            m_write      = 1'b1;
            m_address    = r_dst_ptr;
            w_next       = w_finish ? ST_IDLE : ST_RD;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      s_readdata = '0;
      case (s_address)
         2'd0:    s_readdata[ADDR_W-1:0] = r_src_ptr;
         2'd1:    s_readdata[ADDR_W-1:0] = r_dst_ptr;
         2'd2:    s_readdata[LEN_W-1:0]  = r_rem;
         default: s_readdata[3:0]        = {r_aborted, r_irq_en, r_done, w_busy};
      endcase
   end

   // Later assignments take priority: start over clear, completion over clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_src        <= '0;
         r_dst        <= '0;
         r_len        <= '0;
         r_src_ptr    <= '0;
         r_dst_ptr    <= '0;
         r_rem        <= '0;
         r_buf        <= '0;
         r_done       <= 1'b0;
         r_aborted    <= 1'b0;
         r_irq_en     <= 1'b0;
         r_abort_pend <= 1'b0;
      end else begin
         if (w_csr_wr && !w_busy) begin
            case (s_address)
               2'd0:    r_src <= s_writedata[ADDR_W-1:0];
               2'd1:    r_dst <= s_writedata[ADDR_W-1:0];
               2'd2:    r_len <= w_len_sat;
               default: ;
            endcase
         end
         if (w_ctrl_wr) begin
            r_irq_en <= s_writedata[1];
            if (s_writedata[2]) begin
               r_done    <= 1'b0;
               r_aborted <= 1'b0;
            end
            if (s_writedata[3] && w_busy) r_abort_pend <= 1'b1;
         end
         if (w_start) begin
            r_src_ptr    <= r_src;
            r_dst_ptr    <= r_dst;
            r_rem        <= r_len;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_done       <= (r_len == '0);
         end
         if (r_state == ST_CAP) r_buf <= m_readdata;
         if (r_state == ST_WR) begin
            r_src_ptr <= r_src_ptr + ADDR_W'(1);
            r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
            r_rem     <= w_rem_dec;
            if (w_finish) begin
               r_done       <= 1'b1;
               r_aborted    <= (w_rem_dec != '0);
               r_abort_pend <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_msoc_mem_copy_dma.sv
// Bench for msoc_mem_copy_dma: bench-side RAM, golden memory image and an expected
// per-cycle bus trace built from the copy rules, checked every negedge.
module tb_msoc_mem_copy_dma;

   localparam int AW    = 13;
   localparam int DW    = 32;
   localparam int DEPTH = 8192;

   typedef struct packed {
      logic          cs;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } bus_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    s_address;
   logic          s_chipselect, s_write, s_read;
   logic [31:0]   s_writedata, s_readdata;
   logic          irq;
   logic [AW-1:0] m_address;
   logic [3:0]    m_byteenable;
   logic          m_chipselect, m_write, m_clken;
   logic [DW-1:0] m_writedata;
   logic [DW-1:0] rdata;

   logic [DW-1:0] mem    [DEPTH];
   logic [DW-1:0] golden [DEPTH];
   logic          bd_fill = 1'b0, bd_we = 1'b0;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_data, fill_seed;

   bus_t          trace_q[$];
   bit            mon_on = 1'b0;
   int unsigned   checks = 0, errors = 0;

   msoc_mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(14)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_address(s_address), .s_chipselect(s_chipselect), .s_write(s_write),
      .s_read(s_read), .s_writedata(s_writedata), .s_readdata(s_readdata),
      .irq(irq), .m_address(m_address), .m_byteenable(m_byteenable),
      .m_chipselect(m_chipselect), .m_write(m_write), .m_writedata(m_writedata),
      .m_clken(m_clken), .m_readdata(rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] fillval(input int unsigned i, input logic [DW-1:0] seed);
      return (i * 32'h9E37_79B1) ^ seed;
   endfunction

   // Single-port RAM: registered read data valid the cycle after a read access.
   always @(posedge clk) begin
      if (bd_fill) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= fillval(i, fill_seed);
      end else if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (m_clken && m_chipselect) begin
         if (m_write) mem[m_address] <= m_writedata;
         else         rdata <= mem[m_address];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         bus_t       e;
         logic [51:0] a, x;
         e = '0;
         if (trace_q.size() != 0) e = trace_q.pop_front();
         a = {m_chipselect, m_write, m_chipselect ? m_address : {AW{1'b0}},
              m_write ? m_writedata : {DW{1'b0}}, m_byteenable, m_clken};
         x = {e.cs, e.wr, e.addr, e.data, 4'hF, reset_n};
         chk("bus", 64'(a), 64'(x));
      end
   end

   task automatic idle_bus();
      s_chipselect = 1'b0; s_write = 1'b0; s_read = 1'b0;
      s_address = 2'd0; s_writedata = '0;
   endtask

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      s_chipselect = 1'b1; s_write = 1'b1; s_read = 1'b0; s_address = a; s_writedata = d;
      @(posedge clk); #1;
      idle_bus();
   endtask

   task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      s_chipselect = 1'b1; s_read = 1'b1; s_write = 1'b0; s_address = a;
      @(negedge clk);
      d = s_readdata;
      idle_bus();
   endtask

   task automatic bd_write(input int unsigned a, input logic [DW-1:0] d);
      @(posedge clk); #1;
      bd_we = 1'b1; bd_addr = AW'(a); bd_data = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
      golden[a] = d;
   endtask

   // Copy semantics: ascending word order, each write visible to later reads.
   task automatic build_trace(input int unsigned src, input int unsigned dst, input int words);
      for (int i = 0; i < words; i++) begin
         int unsigned ra, wa;
         logic [DW-1:0] v;
         ra = (src + i) % DEPTH;
         wa = (dst + i) % DEPTH;
         v  = golden[ra];
         trace_q.push_back('{cs: 1'b1, wr: 1'b0, addr: AW'(ra), data: '0});
         trace_q.push_back('0);
         trace_q.push_back('{cs: 1'b1, wr: 1'b1, addr: AW'(wa), data: v});
         golden[wa] = v;
      end
   endtask

   task automatic ram_check(input string name);
      int mism = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== golden[i]) mism++;
      chk(name, mism, 0);
   endtask

   task automatic run_copy(input int src, input int dst, input int len_w, input bit irq_in,
                           input int abort_at, input bit guard, input bit clr_last,
                           output int o_dur, output int o_rem, output int o_src);
      int n, words, dur;
      bit exp_abort, irq_fin, skip;
      logic [31:0] stat, d;
      n = (len_w > DEPTH) ? DEPTH : len_w;
      words = n;
      if (abort_at >= 0 && n > 0 && (abort_at / 3 + 1) < n) words = abort_at / 3 + 1;
      exp_abort = (words < n);
      irq_fin = irq_in;
      csr_wr(2'd0, 32'(src));
      csr_wr(2'd1, 32'(dst));
      csr_wr(2'd2, 32'(len_w));
      @(posedge clk); #1;
      s_chipselect = 1'b1; s_write = 1'b1; s_address = 2'd3;
      s_writedata = {30'b0, irq_in, 1'b1};
      @(posedge clk); #1;
      build_trace(src, dst, words);
      dur = -1;
      stat = '0;
      for (int j = 0; j < 3 * n + 20; j++) begin
         s_chipselect = 1'b1; s_read = 1'b1; s_write = 1'b0; s_address = 2'd3; s_writedata = '0;
         skip = 1'b0;
         if (guard && j == 2) begin
            s_read = 1'b0; s_write = 1'b1; s_address = 2'd0; s_writedata = 32'h55; skip = 1'b1;
         end else if (guard && j == 5) begin
            irq_fin = !irq_fin;
            s_read = 1'b0; s_write = 1'b1; s_writedata = {30'b0, irq_fin, 1'b1};
         end else if (j == abort_at) begin
            s_read = 1'b0; s_write = 1'b1; s_writedata = {28'b0, 4'b1000} | {30'b0, irq_fin, 1'b0};
         end else if (clr_last && j == 3 * n - 1) begin
            s_read = 1'b0; s_write = 1'b1; s_writedata = {28'b0, 4'b0100} | {30'b0, irq_fin, 1'b0};
         end
         @(negedge clk);
         if (!skip && !s_readdata[0]) begin
            dur = j;
            stat = s_readdata;
            break;
         end
         @(posedge clk); #1;
      end
      idle_bus();
      chk("busy_cycles", 64'(dur), 64'(3 * words));
      chk("status_at_end", stat, {28'b0, exp_abort, irq_fin, 1'b1, 1'b0});
      chk("irq_at_end", irq, irq_fin);
      csr_rd(2'd2, d);
      chk("rem", d, 32'(n - words));
      o_rem = int'(d);
      csr_rd(2'd0, d);
      chk("src_ptr", d, 32'((src + words) % DEPTH));
      o_src = int'(d);
      csr_rd(2'd1, d);
      chk("dst_ptr", d, 32'((dst + words) % DEPTH));
      ram_check("ram");
      o_dur = dur;
   endtask

   task automatic reset_checks();
      chk("rst_bus", {m_chipselect, m_write, m_address, m_writedata, m_clken, irq}, '0);
      for (int a = 0; a < 4; a++) begin
         s_address = 2'(a);
         #1;
         chk("rst_csr", s_readdata, 32'h0);
      end
   endtask

   task automatic reset_mid_copy();
      csr_wr(2'd0, 32'h700);
      csr_wr(2'd1, 32'h780);
      csr_wr(2'd2, 32'd10);
      @(posedge clk); #1;
      s_chipselect = 1'b1; s_write = 1'b1; s_address = 2'd3; s_writedata = 32'h1;
      @(posedge clk); #1;
      build_trace(32'h700, 32'h780, 5);
      idle_bus();
      repeat (15) @(posedge clk);
      #1;
      reset_n = 1'b0;
      trace_q.delete();
      repeat (3) begin
         @(negedge clk);
         reset_checks();
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      s_address = 2'd0;
      ram_check("ram_after_reset");
   endtask

   initial begin
      int dur, rem, srcp;
      logic [31:0] d;
      idle_bus();
      reset_n = 1'b0;
      fill_seed = $urandom;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_checks();
      @(posedge clk); #1;
      reset_n = 1'b1;
      mon_on = 1'b1;

      @(posedge clk); #1; bd_fill = 1'b1;
      @(posedge clk); #1; bd_fill = 1'b0;
      for (int i = 0; i < DEPTH; i++) golden[i] = fillval(i, fill_seed);

      // Basic four-word copy
      for (int i = 0; i < 4; i++) bd_write(32'h100 + i, 32'hA000_0000 + i);
      run_copy(32'h100, 32'h200, 4, 1'b0, -1, 1'b0, 1'b0, dur, rem, srcp);
      chk("basic_busy_12", 64'(dur), 64'd12);
      chk("basic_rem_0", 64'(rem), 64'd0);
      for (int i = 0; i < 4; i++) chk("basic_data", mem[32'h200 + i], 32'hA000_0000 + i);

      // Pointer wrap
      run_copy(32'h1FFE, 32'h0010, 4, 1'b0, -1, 1'b0, 1'b0, dur, rem, srcp);
      chk("wrap_src_2", 64'(srcp), 64'd2);

      // Zero length with interrupt enabled
      run_copy(32'h300, 32'h400, 0, 1'b1, -1, 1'b0, 1'b0, dur, rem, srcp);
      chk("zero_busy_0", 64'(dur), 64'd0);
      csr_rd(2'd3, d);
      chk("zero_irq_held", {irq, d}, {1'b1, 32'h6});
      csr_wr(2'd3, 32'h6);
      csr_rd(2'd3, d);
      chk("zero_irq_cleared", {irq, d}, {1'b0, 32'h4});

      // Abort at cycle 20 with SRC write and restart attempted mid-copy
      run_copy(32'h800, 32'h900, 100, 1'b0, 20, 1'b1, 1'b0, dur, rem, srcp);
      chk("abort_busy_21", 64'(dur), 64'd21);
      chk("abort_rem_93", 64'(rem), 64'd93);
      chk("abort_src", 64'(srcp), 64'h807);

      // Overlapping forward copy propagates the first word
      for (int i = 0; i < 4; i++) bd_write(i, 32'(i + 1));
      run_copy(0, 1, 3, 1'b0, -1, 1'b0, 1'b0, dur, rem, srcp);
      for (int i = 0; i < 4; i++) chk("overlap_data", mem[i], 32'h1);

      // Clear written in the final WR cycle loses to completion
      run_copy(32'h1234, 32'h0345, 5, 1'b1, -1, 1'b0, 1'b1, dur, rem, srcp);

      // LEN saturates to 8192
      run_copy(0, 32'h1000, 32'h3FFF, 1'b0, -1, 1'b0, 1'b0, dur, rem, srcp);
      chk("sat_busy", 64'(dur), 64'd24576);

      for (int k = 0; k < 12; k++) begin
         int len, ab;
         bit g;
         len = int'($urandom_range(1, 48));
         g = (len >= 2) && ($urandom_range(0, 1) == 1);
         ab = -1;
         if ($urandom_range(0, 2) == 0) begin
            ab = int'($urandom_range(0, 3 * len - 1));
            if (g && ab < 6) ab = -1;
         end
         run_copy(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)), len,
                  1'($urandom_range(0, 1)), ab, g, 1'($urandom_range(0, 1)), dur, rem, srcp);
      end

      reset_mid_copy();
      run_copy(32'h0ABC, 32'h1F00, 7, 1'b1, -1, 1'b0, 1'b0, dur, rem, srcp);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
